fx_match_sched: RTL and testbench
=================================

# fx_match_sched

Round-robin scheduler that time-shares one fixed-point format-match unit (13-bit to 14-bit sign-extending resize followed by a fixed 3-cycle delay line) among several requesters. It arbitrates valid/ready requests and drives the shared unit's input. A tag pipeline matched to the unit's latency routes each result back to its originator. The block sits between the M2V-generated datapath stages and the single shared FxMatch instance, and also sequences enable/drain/flush of that resource.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IW`, 13: input word width, two's complement.
- `OW`, 14: output word width, two's complement.
- `LAT`, 3: pure register latency of the shared unit, in cycles (1..8).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_enable`  in  1  scheduler may issue new requests.
- `i_flush`  in  1  single-cycle pulse; discards all in-flight results.
- `i_req_valid`  in  NREQ  per-requester request valid.
- `i_req_data`  in  NREQ*IW  per-requester operand; slice k belongs to requester k.
- `o_req_ready`  out  NREQ  one-hot grant, combinational.
- `o_fx_data`  out  IW  registered operand to the shared unit.
- `i_fx_data`  in  OW  result from the shared unit.
- `o_rsp_valid`  out  NREQ  one-hot result strobe.
- `o_rsp_data`  out  OW  result word, valid when any `o_rsp_valid` bit is set.
- `o_busy`  out  1  at least one result is in flight.
- `o_state`  out  2  FSM state: 0=IDLE, 1=RUN, 2=DRAIN.

## Operation
- Requester protocol: valid/ready. A requester holds `i_req_valid` and its data stable until it sees ready. A transfer happens at a rising edge where `i_req_valid[k] & o_req_ready[k]`.
- Grant rule:
  - In RUN, exactly one ready bit is asserted: the first requester with valid at or after the RR pointer, wrapping modulo NREQ.
  - Ready is all-zero when nothing is valid, in IDLE, in DRAIN, and during the `i_flush` cycle.
- RR pointer: resets to 0. After a grant to k it becomes (k+1) mod NREQ; otherwise it holds.
- Issue: on a transfer, `o_fx_data` <= the granted operand. The tag pipeline stage 0 <= {valid=1, one-hot k}. With no transfer, stage 0 valid <= 0 and `o_fx_data` holds its value.
- Tag pipeline: LAT stages that shift every cycle.
  - `o_rsp_valid` = the last stage's one-hot when that stage is valid; else 0.
  - `o_rsp_data` = `i_fx_data`, passed through combinationally.
  - Results carry no backpressure; consumers must accept them.
- Flush: `i_flush` clears every tag-stage valid bit at the next edge. No grant occurs in that cycle. Results already in the shared unit emerge with `o_rsp_valid`=0.
- `o_busy` = OR of all tag-stage valid bits.
- FSM:
  - IDLE -> RUN when `i_enable`=1.
  - RUN -> DRAIN when `i_enable`=0 and `o_busy`=1.
  - RUN -> IDLE when `i_enable`=0 and `o_busy`=0.
  - DRAIN -> IDLE when `o_busy`=0.
  - DRAIN -> RUN when `i_enable`=1. This takes priority over DRAIN -> IDLE.
  - A flush in any state leaves the state unchanged.
- Shared unit behaviour the bench models: `i_fx_data` = sign-extended `o_fx_data` delayed LAT cycles. The scheduler itself performs no arithmetic.

## Timing
- Reset values:
  - `o_req_ready`=0.
  - `o_fx_data`=0.
  - `o_rsp_valid`=0.
  - `o_busy`=0.
  - `o_state`=IDLE.
  - RR pointer=0.
  - All tag valid bits=0.
- Reset mid-operation drops all in-flight tags immediately and asynchronously.
- Latency: a transfer at edge E0 produces `o_rsp_valid` during the cycle following edge E0+LAT.
- Throughput: one transfer per cycle sustained. With all requesters valid, grants rotate 0,1,2,3,0,…
- Simultaneous events:
  - `i_flush` with `i_enable` falling: the flush applies and the FSM goes to IDLE (busy is cleared).
  - `i_flush` on the same edge a result exits: that result is still presented, because the last stage is sampled before the clear.
- `o_req_ready` depends combinationally only on `i_req_valid`, the RR pointer, the state and `i_flush`. It has no path from `i_fx_data`.

## Structure
- `fx_sched_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the default constants `NREQ_D`=4, `LAT_D`=3;
  - the tag struct {valid, one-hot[NREQ]}.
- One sub-module: `rr_arbiter`, parameter NREQ. It takes the request vector, grant enable and pointer, and returns a one-hot grant plus the next pointer.
- The tag pipeline and FSM stay in the top level.

## Test plan
- Single request: enable, req1 valid with 13'h1000 -> ready[1] in that cycle; `o_fx_data`=13'h1000; `o_rsp_valid`=4'b0010 with `o_rsp_data`=14'h3000 exactly LAT cycles later.
- Full contention: all four valid continuously, operands k*0x111 -> grant order 0,1,2,3,0,1; each response tagged to its owner; positive values zero-extended, e.g. 13'h0333 -> 14'h0333.
- Drain: drop `i_enable` with 3 results in flight -> state DRAIN; no further grants; three responses delivered; IDLE on the cycle after `o_busy` falls.
- Flush: two results in flight, pulse `i_flush` -> no `o_rsp_valid` for those results; `o_busy`=0 next cycle; no grant during the flush cycle.
- Async reset mid-stream: deassert `rst_n` while busy -> all outputs at reset values without waiting for a clock edge; after release, the RR pointer restarts at requester 0.
- Wrap and skip: pointer at 3, only req0 and req2 valid -> grant 0, then 2, then 0.

Source files
------------

// File: rtl/fx_match_sched_pkg.sv
// Shared types and defaults for the FxMatch round-robin scheduler.
// No logic of its own: state encoding, tag record and parameter defaults.
package fx_sched_pkg;

    localparam int NREQ_D   = 4;
    localparam int LAT_D    = 3;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One-hot owner is sized for the largest supported requester count.
    typedef struct packed {
        logic                vld;
        logic [NREQ_MAX-1:0] oh;
    } tag_t;

endpackage

// File: rtl/fx_match_sched_if.sv
// Requester, shared-unit and status signals of the scheduler, bundled.
// slave = scheduler side, master = requesters / shared unit / controller side.
interface fx_match_sched_if
    import fx_sched_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int IW   = 13,
    parameter int OW   = 14
);
    logic                 i_enable;
    logic                 i_flush;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*IW-1:0]   i_req_data;
    logic [NREQ-1:0]      o_req_ready;
    logic [IW-1:0]        o_fx_data;
    logic [OW-1:0]        i_fx_data;
    logic [NREQ-1:0]      o_rsp_valid;
    logic [OW-1:0]        o_rsp_data;
    logic                 o_busy;
    logic [1:0]           o_state;

    modport slave (
        input  i_enable, i_flush, i_req_valid, i_req_data, i_fx_data,
        output o_req_ready, o_fx_data, o_rsp_valid, o_rsp_data, o_busy, o_state
    );

    modport master (
        output i_enable, i_flush, i_req_valid, i_req_data, i_fx_data,
        input  o_req_ready, o_fx_data, o_rsp_valid, o_rsp_data, o_busy, o_state
    );
endinterface

// File: rtl/fx_match_sched_rr_arbiter.sv
// Round-robin pick: first request at or after ptr_i, wrapping; returns next pointer.
// Purely combinational; en_i low forces an empty grant and a held pointer.
module rr_arbiter
    import fx_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_D,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic             en_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W:0] N = (PTR_W+1)'(NREQ);

    logic             hit;
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   nxt;

    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        hit   = 1'b0;
        sum   = '0;
        nxt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr_i < NREQ and i < NREQ, so one conditional subtract is a full modulo.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= N) sum = sum - N;
            if (!hit && en_i && req_i[sum[PTR_W-1:0]]) begin
                hit                   = 1'b1;
                gnt_o[sum[PTR_W-1:0]] = 1'b1;
                nxt                   = sum + (PTR_W+1)'(1);
                ptr_o                 = (nxt == N) ? '0 : nxt[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fx_match_sched.sv
// Time-shares one FxMatch unit among NREQ requesters; tags route results home.
// Latency: grant to o_rsp_valid is LAT cycles; requests backpressured by one-hot ready, results have none.
module fx_match_sched
    import fx_sched_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int IW   = 13,
    parameter int OW   = 14,
    parameter int LAT  = LAT_D
) (
    input  logic              clk,
    input  logic              rst_n,
    fx_match_sched_if.slave   bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [IW-1:0]     fx_q;
    logic [IW-1:0]     fx_d;
    logic [NREQ-1:0]   gnt;
    logic              gnt_en;
    logic              busy;
    logic              busy_eff;
    tag_t              tag_d;
    // Stage 0 travels alongside fx_q; stage LAT lines up with the unit's output.
    tag_t              tag_q [0:LAT];

    assign gnt_en = (state_q == ST_RUN) && !bus.i_flush;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (bus.i_req_valid),
        .en_i  (gnt_en),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .ptr_o (ptr_d)
    );

    always_comb begin
        fx_d = fx_q;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) fx_d = bus.i_req_data[k*IW +: IW];
        end
        tag_d.vld = |gnt;
        tag_d.oh  = NREQ_MAX'(gnt);
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            busy = busy | tag_q[i].vld;
        end
    end

    // A flush empties the pipe at this edge, so the FSM treats busy as already gone.
    assign busy_eff = busy && !bus.i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            fx_q  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            fx_q     <= fx_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i].vld <= tag_q[i-1].vld && !bus.i_flush;
                tag_q[i].oh  <= tag_q[i-1].oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.i_enable) state_q <= ST_RUN;
                ST_RUN:   if (!bus.i_enable) state_q <= busy_eff ? ST_DRAIN : ST_IDLE;
                ST_DRAIN: begin
                    if (bus.i_enable)   state_q <= ST_RUN;
                    else if (!busy_eff) state_q <= ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = gnt;
    assign bus.o_fx_data   = fx_q;
    assign bus.o_rsp_valid = tag_q[LAT].vld ? tag_q[LAT].oh[NREQ-1:0] : '0;
    assign bus.o_rsp_data  = bus.i_fx_data;
    assign bus.o_busy      = busy;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_fx_match_sched.sv
// Bench for fx_match_sched: directed steps then random traffic against a queue-based model.
module tb_fx_match_sched;
    import fx_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IW   = 13;
    localparam int OW   = 14;
    localparam int LAT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fx_match_sched_if #(.NREQ(NREQ), .IW(IW), .OW(OW)) bus ();

    fx_match_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [OW-1:0] sext(input logic [IW-1:0] v);
        return {{(OW-IW){v[IW-1]}}, v};
    endfunction

    // Shared FxMatch unit: sign-extend, then a LAT-register delay line.
    logic [OW-1:0] fx_pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        fx_pipe[0] <= sext(bus.o_fx_data);
        for (int i = 1; i < LAT; i++) fx_pipe[i] <= fx_pipe[i-1];
    end
    assign bus.i_fx_data = fx_pipe[LAT-1];

    // Reference model: each accepted request becomes an expected response due at edge count ec == due.
    typedef struct {
        int            due;
        int            req;
        logic [OW-1:0] val;
    } ent_t;

    ent_t          q[$];
    int            m_state;
    int            m_ptr;
    int            ec;
    logic [IW-1:0] m_fx;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_fx    = '0;
        q.delete();
    endtask

    function automatic int m_grant();
        int k;
        if (m_state != 1 || bus.i_flush) return -1;
        for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (bus.i_req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_cycle(input string tag);
        int              g;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] ev;
        logic [OW-1:0]   ed;
        g  = m_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = '0;
        ed = '0;
        foreach (q[i]) begin
            if (q[i].due == ec) begin
                ev[q[i].req] = 1'b1;
                ed           = q[i].val;
            end
        end
        chk({tag, "_ready"},     32'(bus.o_req_ready), 32'(er));
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'(ev));
        if (ev != '0) chk({tag, "_rsp_data"}, 32'(bus.o_rsp_data), 32'(ed));
        chk({tag, "_busy"},      32'(bus.o_busy), 32'(q.size() > 0));
        chk({tag, "_state"},     32'(bus.o_state), 32'(m_state));
        chk({tag, "_fx_data"},   32'(bus.o_fx_data), 32'(m_fx));
    endtask

    task automatic sc(input string tag);
        #1;
        check_cycle(tag);
    endtask

    task automatic tick(output int g);
        bit   busy_now;
        bit   en;
        bit   fl;
        bit   busy_eff;
        ent_t e;
        g        = m_grant();
        en       = bus.i_enable;
        fl       = bus.i_flush;
        busy_now = (q.size() > 0);
        busy_eff = busy_now && !fl;
        if (g >= 0) begin
            e.due = ec + 1 + LAT;
            e.req = g;
            e.val = sext(bus.i_req_data[g*IW +: IW]);
            q.push_back(e);
            m_fx  = bus.i_req_data[g*IW +: IW];
            m_ptr = (g + 1) % NREQ;
        end
        if (fl) q.delete();
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = busy_eff ? 2 : 0;
            default: begin
                if (en) m_state = 1;
                else if (!busy_eff) m_state = 0;
            end
        endcase
        @(posedge clk);
        ec++;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due < ec) q.delete(i);
        end
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs with no clock edge, releases before the next edge.
    task automatic do_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cycle(tag);
        chk({tag, "_async_busy"},  32'(bus.o_busy), 32'd0);
        chk({tag, "_async_state"}, 32'(bus.o_state), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int nrsp;
        bit done;

        n_tests = 0;
        n_fail  = 0;
        ec      = 0;
        bus.i_enable    = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        model_reset();

        // Reset values
        #3;
        check_cycle("reset");
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 1
        bus.i_enable = 1'b1;
        sc("s1a"); tick(g);
        bus.i_req_valid = 4'b0010;
        bus.i_req_data[1*IW +: IW] = 13'h1000;
        sc("s1b");
        chk("s1_ready", 32'(bus.o_req_ready), 32'h2);
        tick(g);
        bus.i_req_valid = '0;
        sc("s1c");
        chk("s1_fx_data", 32'(bus.o_fx_data), 32'h1000);
        tick(g);
        repeat (2) begin sc("s1w"); tick(g); end
        sc("s1d");
        chk("s1_rsp_valid", 32'(bus.o_rsp_valid), 32'h2);
        chk("s1_rsp_data", 32'(bus.o_rsp_data), 32'h3000);
        tick(g);

        // Full contention from a fresh pointer
        do_reset("s2rst"); tick(g);
        bus.i_req_valid = 4'hF;
        for (int k = 0; k < NREQ; k++) bus.i_req_data[k*IW +: IW] = IW'(k * 13'h111);
        for (int i = 0; i < 11; i++) begin
            if (i == 6) bus.i_req_valid = '0;
            sc("s2");
            if (i < 6) chk("s2_order", 32'(bus.o_req_ready), 32'(1 << (i % NREQ)));
            if (bus.o_rsp_valid == 4'b1000) chk("s2_rsp3", 32'(bus.o_rsp_data), 32'h0333);
            tick(g);
        end

        // Drain with three results in flight
        bus.i_req_valid = 4'hF;
        repeat (3) begin sc("s3g"); tick(g); end
        bus.i_enable    = 1'b0;
        bus.i_req_valid = '0;
        sc("s3b"); tick(g);
        sc("s3c");
        chk("s3_state_drain", 32'(bus.o_state), 32'd2);
        bus.i_req_valid = 4'hF;
        nrsp = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            sc("s3d");
            chk("s3_no_grant", 32'(bus.o_req_ready), 32'd0);
            if (bus.o_rsp_valid != '0) nrsp++;
            if (!bus.o_busy) done = 1'b1;
            tick(g);
        end
        chk("s3_busy_fell", 32'(done), 32'd1);
        chk("s3_nrsp", 32'(nrsp), 32'd3);
        sc("s3e");
        chk("s3_idle", 32'(bus.o_state), 32'd0);

        // Flush with two results in flight
        bus.i_req_valid = '0;
        bus.i_enable    = 1'b1;
        sc("s4r"); tick(g);
        bus.i_req_valid = 4'b0011;
        repeat (2) begin sc("s4g"); tick(g); end
        bus.i_req_valid = 4'hF;
        bus.i_flush     = 1'b1;
        sc("s4a");
        chk("s4_flush_ready", 32'(bus.o_req_ready), 32'd0);
        chk("s4_flush_busy", 32'(bus.o_busy), 32'd1);
        tick(g);
        bus.i_flush     = 1'b0;
        bus.i_req_valid = '0;
        nrsp = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            sc("s4b");
            if (i == 0) chk("s4_busy_clear", 32'(bus.o_busy), 32'd0);
            if (bus.o_rsp_valid != '0) nrsp++;
            tick(g);
        end
        chk("s4_no_rsp", 32'(nrsp), 32'd0);

        // Async reset while busy
        bus.i_req_valid = 4'hF;
        repeat (2) begin sc("s5g"); tick(g); end
        chk("s5_busy_before", 32'(bus.o_busy), 32'd1);
        do_reset("s5rst"); tick(g);
        sc("s5b");
        chk("s5_ptr_restart", 32'(bus.o_req_ready), 32'h1);
        tick(g);

        // Wrap and skip from pointer 3
        bus.i_req_valid = 4'b0100;
        sc("s6a"); tick(g);
        bus.i_req_valid = 4'b0101;
        sc("s6b"); chk("s6_first", 32'(bus.o_req_ready), 32'h1); tick(g);
        sc("s6c"); chk("s6_second", 32'(bus.o_req_ready), 32'h4); tick(g);
        sc("s6d"); chk("s6_third", 32'(bus.o_req_ready), 32'h1); tick(g);
        bus.i_req_valid = '0;

        // Random traffic with enable toggles, flushes and occasional resets
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) bus.i_enable = ~bus.i_enable;
            bus.i_flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.i_req_valid[k] && $urandom_range(0, 1) == 1) begin
                    bus.i_req_valid[k]         = 1'b1;
                    bus.i_req_data[k*IW +: IW] = IW'($urandom);
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                sc("rnd");
            end
            tick(g);
            if (g >= 0) begin
                bus.i_req_valid[g]         = 1'($urandom_range(0, 1));
                bus.i_req_data[g*IW +: IW] = IW'($urandom);
            end
        end

        bus.i_flush     = 1'b0;
        bus.i_enable    = 1'b0;
        bus.i_req_valid = '0;
        repeat (LAT + 3) begin sc("tail"); tick(g); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
